fetch_controller: RTL and testbench

Instruction-fetch sequencer that reads from the 10-bit program counter and is the only source of the counter's pc_en increment strobe. It issues one instruction-memory read per instruction at the current PC value and waits a fixed memory latency. It then latches the returned word into an instruction register and presents it to the decode/execute stage through a valid/ready handshake. It sits between the program counter, the instruction BRAM and the control unit.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_lat_timer.sv | 33 +++
 rtl/fetch_controller.sv | 102 ++++++++++
 tb/tb_fetch_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch path: FSM state encoding,
// default bus widths and the legal range of the memory read latency.
// No ports; imported by fetch_controller and fetch_lat_timer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam int ADDR_W_DEF  = 10;
  localparam int INSTR_W_DEF = 16;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;

endpackage

// File: rtl/fetch_lat_timer.sv
// Loadable down-counter that times a synchronous memory read.
// Ports: clk/rst (async active-low); load presets MEM_LAT-1; dec counts down
// towards zero and holds there; zero flags the last wait cycle.
module fetch_lat_timer
  import fetch_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  // Sized for the largest legal latency so every instance shares one width.
  localparam int CNT_W = $clog2(MEM_LAT_MAX);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(MEM_LAT - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: one memory read per instruction, captures the
// returned word into ir and hands it downstream with a valid/ready handshake.
// Ports: clk/rst (async active-low); pc in, pc_en strobe out; mem_rd/mem_addr/
// mem_rdata to the instruction memory; ir/ir_valid/ir_ready to decode;
// halt/flush control; busy while not idle. All outputs registered.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_en,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               halt,
  input  logic               flush,
  output logic               busy
);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic lat_zero;
  logic capture;
  logic handoff;

  fetch_lat_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_timer (
    .clk  (clk),
    .rst  (rst),
    .load (state == ISSUE),
    .dec  (state == WAIT),
    .zero (lat_zero)
  );

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    handoff   = 1'b0;
    // Flush overrides capture and the handshake in every state.
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (!halt) state_nxt = ISSUE;
        ISSUE: state_nxt = WAIT;
        WAIT: begin
          if (lat_zero) begin
            capture   = 1'b1;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (ir_valid && ir_ready) begin
            handoff   = 1'b1;
            state_nxt = halt ? IDLE : ISSUE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc_en    <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      ir       <= '0;
      ir_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= (state_nxt != IDLE);
      mem_rd <= (state_nxt == ISSUE);
      pc_en  <= capture;
      // A handoff on the first HOLD cycle coincides with the counter's own
      // increment edge, so pc still shows the old value; forward the value
      // the counter is moving to so the next fetch reads the next word.
      if (state_nxt == ISSUE) begin
        mem_addr <= pc_en ? (pc + ADDR_W'(1)) : pc;
      end
      if (capture) begin
        ir       <= mem_rdata;
        ir_valid <= 1'b1;
      end else if (flush || handoff) begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller at MEM_LAT=1 and MEM_LAT=3 side by side.
// Reference: the accepted instruction stream must be imem[0], imem[1], ... in
// order; every read must target the index of the next instruction to be consumed.
module tb_fetch_controller;

  localparam int N = 2;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        halt_a     [N];
  logic        flush_a    [N];
  logic        ready_a    [N];
  logic        pc_en_a    [N];
  logic        mem_rd_a   [N];
  logic        ir_valid_a [N];
  logic        busy_a     [N];
  logic [9:0]  mem_addr_a [N];
  logic [15:0] ir_a       [N];

  logic [15:0] imem [1024];

  // ---------------- environment: program counter + synchronous memory -----
  for (genvar g = 0; g < N; g++) begin : g_env
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [9:0]  pc;
    logic [15:0] pipe [LAT];

    always @(posedge clk or negedge rst) begin
      if (!rst) pc <= '0;
      else if (pc_en_a[g]) pc <= pc + 10'd1;
    end

    // Junk on idle cycles so a capture at the wrong moment is visible.
    always @(posedge clk) begin
      pipe[0] <= mem_rd_a[g] ? imem[mem_addr_a[g]] : 16'($urandom);
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end

    fetch_controller #(
      .ADDR_W  (10),
      .INSTR_W (16),
      .MEM_LAT (LAT)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .pc        (pc),
      .pc_en     (pc_en_a[g]),
      .mem_rd    (mem_rd_a[g]),
      .mem_addr  (mem_addr_a[g]),
      .mem_rdata (pipe[LAT-1]),
      .ir        (ir_a[g]),
      .ir_valid  (ir_valid_a[g]),
      .ir_ready  (ready_a[g]),
      .halt      (halt_a[g]),
      .flush     (flush_a[g]),
      .busy      (busy_a[g])
    );
  end

  // ---------------- scoreboard / monitor ----------------------------------
  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  logic [15:0] exp_q [N][$];
  int          consumed  [N];
  int          hs_total  [N];
  int          since_rst [N];
  int          issue_cyc [N];
  int          pe_cnt    [N];
  logic        prev_iv [N], prev_ready [N], prev_hs [N];
  logic        prev_halt [N], prev_busy [N], prev_flush [N];
  logic [15:0] prev_ir [N];

  bit done       = 1'b0;
  bit final_done = 1'b0;
  bit wait_to    = 1'b0;

  task automatic chk(input bit ok, input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] expv);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s lat=%0d t=%0t actual=%0h required=%0h",
                  name, lat_of(inst), $time, act, expv);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      consumed[i] = 0; hs_total[i] = 0; since_rst[i] = 0;
      issue_cyc[i] = 0; pe_cnt[i] = 0;
    end
  end

  always @(negedge clk) begin
    logic [15:0] expw;
    cyc = cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        chk({pc_en_a[i], mem_rd_a[i], ir_valid_a[i], busy_a[i], mem_addr_a[i], ir_a[i]} == '0,
            "reset_outputs", i,
            {2'b0, pc_en_a[i], mem_rd_a[i], ir_valid_a[i], busy_a[i], mem_addr_a[i], ir_a[i]}, 0);
        exp_q[i].delete();
        consumed[i] = 0; since_rst[i] = 0; pe_cnt[i] = 0;
        prev_iv[i] = 0; prev_ready[i] = 0; prev_hs[i] = 0;
        prev_halt[i] = 0; prev_busy[i] = 0; prev_flush[i] = 0; prev_ir[i] = '0;
      end else begin
        if (since_rst[i] < 1000) since_rst[i]++;
        if (since_rst[i] == 1) chk(!mem_rd_a[i], "idle_after_release", i, 32'(mem_rd_a[i]), 0);
        if (since_rst[i] == 2) chk(mem_rd_a[i], "first_issue_cycle", i, 32'(mem_rd_a[i]), 1);
        if (prev_hs[i]) begin
          chk(mem_rd_a[i] == !prev_halt[i], "handoff_next", i, 32'(mem_rd_a[i]), 32'(!prev_halt[i]));
          chk(ir_a[i] == prev_ir[i], "ir_kept_after_hs", i, 32'(ir_a[i]), 32'(prev_ir[i]));
        end
        if (!prev_busy[i] && prev_halt[i] && since_rst[i] > 1)
          chk(!mem_rd_a[i] && !busy_a[i], "halt_stays_idle", i, {mem_rd_a[i], busy_a[i]}, 0);
        if (prev_flush[i])
          chk({ir_valid_a[i], mem_rd_a[i], pc_en_a[i], busy_a[i]} == 4'b0, "flush_abort", i,
              {ir_valid_a[i], mem_rd_a[i], pc_en_a[i], busy_a[i]}, 0);

        if (mem_rd_a[i]) begin
          chk(mem_addr_a[i] == 10'(consumed[i]), "issue_addr", i, 32'(mem_addr_a[i]), 32'(10'(consumed[i])));
          chk(exp_q[i].size() == 0, "no_overlap", i, exp_q[i].size(), 0);
          exp_q[i].push_back(imem[consumed[i] % 1024]);
          issue_cyc[i] = cyc;
        end
        chk(busy_a[i] == ((exp_q[i].size() != 0) || ir_valid_a[i]), "busy", i,
            32'(busy_a[i]), 32'((exp_q[i].size() != 0) || ir_valid_a[i]));

        if (ir_valid_a[i] && !prev_iv[i]) begin
          chk(cyc - issue_cyc[i] == lat_of(i) + 1, "valid_latency", i, cyc - issue_cyc[i], lat_of(i) + 1);
          chk(pc_en_a[i], "pc_en_on_capture", i, 32'(pc_en_a[i]), 1);
          pe_cnt[i] = 0;
        end
        if (!ir_valid_a[i]) chk(!pc_en_a[i], "no_stray_pc_en", i, 32'(pc_en_a[i]), 0);
        else pe_cnt[i] += int'(pc_en_a[i]);
        if (ir_valid_a[i] && prev_iv[i] && !prev_ready[i])
          chk(ir_a[i] == prev_ir[i], "ir_held_stall", i, 32'(ir_a[i]), 32'(prev_ir[i]));

        if (ir_valid_a[i] && ready_a[i]) begin
          if (exp_q[i].size() == 0) begin
            chk(1'b0, "unexpected_ir", i, 32'(ir_a[i]), 0);
          end else begin
            expw = exp_q[i].pop_front();
            chk(ir_a[i] == expw, "ir_value", i, 32'(ir_a[i]), 32'(expw));
          end
          chk(pe_cnt[i] == 1, "one_pc_en", i, pe_cnt[i], 1);
          consumed[i]++;
          hs_total[i]++;
        end
        if (flush_a[i]) exp_q[i].delete();

        prev_hs[i]    = ir_valid_a[i] && ready_a[i];
        prev_iv[i]    = ir_valid_a[i];
        prev_ready[i] = ready_a[i];
        prev_halt[i]  = halt_a[i];
        prev_busy[i]  = busy_a[i];
        prev_flush[i] = flush_a[i];
        prev_ir[i]    = ir_a[i];
      end
    end
    if (done && !final_done) begin
      final_done = 1'b1;
      chk(!wait_to, "wait_state_reached", 1, 32'(wait_to), 0);
      for (int i = 0; i < N; i++)
        chk(hs_total[i] >= 50, "progress", i, hs_total[i], 50);
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic random_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        ready_a[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) halt_a[i] = !halt_a[i];
        // Flush only before capture, so a flushed fetch never advanced the PC.
        flush_a[i] = !ir_valid_a[i] && ($urandom_range(0, 19) == 0);
      end
    end
  endtask

  task automatic quiet_inputs();
    for (int i = 0; i < N; i++) begin
      halt_a[i] = 1'b0; flush_a[i] = 1'b0; ready_a[i] = 1'b1;
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    quiet_inputs();
    for (int k = 0; k < 1024; k++) imem[k] = 16'($urandom);
    imem[0] = 16'hA5C3;
    imem[1] = 16'h1234;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    repeat (30) @(posedge clk);      // back-to-back streaming
    random_cycles(1500);

    // Reset while the MEM_LAT=3 instance is waiting on memory.
    #0 quiet_inputs();
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(posedge clk); #1;
      if (busy_a[1] && !mem_rd_a[1] && !ir_valid_a[1]) found = 1'b1;
    end
    wait_to = !found;
    #2 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    random_cycles(500);

    done = 1'b1;
    repeat (3) @(negedge clk);
    #1 $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
